// File: rtl/bsg_tag_serial_tx_pkg.sv
// Shared types and helpers for the bsg_tag serial transmitter.
package bsg_tag_serial_tx_pkg;

  // Transmit sequencer states. The state held in the register is always the
  // field whose bit is currently on tag_data_o.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_NODE    = 3'd2,
    S_DNR     = 3'd3,
    S_LEN     = 3'd4,
    S_PAYLOAD = 3'd5,
    S_RST     = 3'd6,
    S_GAP     = 3'd7
  } tx_state_e;

  // Elaboration-time maximum, used to size the shared bit counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_tag_serial_tx.sv
// Host-side bsg_tag serial transmitter. Takes one command per valid/ready
// handshake and emits either a client packet or a master-reset sequence on
// tag_data_o/tag_en_o, LSB first within every field, both outputs registered.
module bsg_tag_serial_tx
  import bsg_tag_serial_tx_pkg::*;
#(
  parameter int els_p       = 54,
  parameter int lg_width_p  = 4,
  parameter int gap_p       = 2,
  parameter int reset_len_p = 2 * (3 + $clog2(els_p) + lg_width_p + (2**lg_width_p - 1))
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic                        master_reset_i,
  input  logic [$clog2(els_p)-1:0]    node_id_i,
  input  logic                        data_not_reset_i,
  input  logic [lg_width_p-1:0]       len_i,
  input  logic [2**lg_width_p-2:0]    payload_i,
  output logic                        tag_data_o,
  output logic                        tag_en_o,
  output logic                        busy_o
);

  localparam int node_w  = $clog2(els_p);
  localparam int max_len = 2**lg_width_p - 1;
  // The counter must reach the last index of the longest field of any kind.
  localparam int cnt_max = max_int(max_int(reset_len_p, max_len),
                                   max_int(max_int(node_w, lg_width_p), gap_p));
  localparam int cnt_w   = $clog2(cnt_max + 1);
  // Shift register holds node, dnr, len and payload back to back in the
  // order they go out, so one right shift per emitted bit walks all fields.
  localparam int sh_w    = node_w + 1 + lg_width_p + max_len;

  typedef logic [cnt_w-1:0] cnt_t;

  typedef struct packed {
    logic                    master_reset;
    logic [node_w-1:0]       node_id;
    logic                    data_not_reset;
    logic [lg_width_p-1:0]   len;
    logic [max_len-1:0]      payload;
  } cmd_s;

  cmd_s                  cmd_in;

  logic [1:0]            rst_sync_reg;
  logic                  rst_n;

  tx_state_e             state_reg, state_next;
  cnt_t                  cnt_reg, cnt_next;
  cnt_t                  field_last;
  logic                  field_done;
  logic [lg_width_p-1:0] len_reg, len_next;
  logic [sh_w-1:0]       sh_reg, sh_next;
  logic                  data_reg, data_next;
  logic                  en_reg, en_next;
  logic                  accept;

  // Bundle the command inputs so the latch point sees one coherent word.
  always_comb begin
    cmd_in                = '0;
    cmd_in.master_reset   = master_reset_i;
    cmd_in.node_id        = node_id_i;
    cmd_in.data_not_reset = data_not_reset_i;
    cmd_in.len            = len_i;
    cmd_in.payload        = payload_i;
  end

  // Reset asserts immediately but releases only on a clock edge, two flops deep.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_reg[1];

  assign ready_o = (state_reg == S_IDLE);
  assign busy_o  = ~ready_o;
  assign accept  = v_i & ready_o;

  // Index of the final bit of the field currently being sent.
  always_comb begin
    field_last = '0;
    case (state_reg)
      S_NODE:    field_last = cnt_t'(node_w - 1);
      S_LEN:     field_last = cnt_t'(lg_width_p - 1);
      S_PAYLOAD: field_last = cnt_t'(len_reg) - cnt_t'(1);
      S_RST:     field_last = cnt_t'(reset_len_p - 1);
      S_GAP:     field_last = cnt_t'(gap_p - 1);
      default:   field_last = '0;
    endcase
  end

  assign field_done = (cnt_reg == field_last);

  // Next-state sequencing, counter update and the next output bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    sh_next    = sh_reg;
    data_next  = 1'b0;
    en_next    = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = cmd_in.master_reset ? S_RST : S_START;
          len_next   = cmd_in.len;
          sh_next    = {cmd_in.payload, cmd_in.len, cmd_in.data_not_reset, cmd_in.node_id};
        end
      end
      S_START:   state_next = S_NODE;
      S_NODE:    if (field_done) state_next = S_DNR;
      S_DNR:     state_next = S_LEN;
      S_LEN: begin
        if (field_done) begin
          state_next = (len_reg == '0) ? S_GAP : S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (field_done) state_next = S_GAP;
      S_RST:     if (field_done) state_next = S_GAP;
      S_GAP:     if (field_done) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase

    // The counter restarts on every field change and never runs in IDLE.
    if (state_next != state_reg || state_next == S_IDLE) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + cnt_t'(1);
    end

    // Output register is loaded with the bit belonging to the next state.
    case (state_next)
      S_IDLE: begin
        data_next = 1'b0;
        en_next   = 1'b0;
      end
      S_START, S_RST: data_next = 1'b1;
      S_NODE, S_DNR, S_LEN, S_PAYLOAD: begin
        data_next = sh_reg[0];
        sh_next   = sh_reg >> 1;
      end
      S_GAP:   data_next = 1'b0;
      default: data_next = 1'b0;
    endcase
  end

  // Sequencer state, field counter, latched command and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      sh_reg    <= '0;
      data_reg  <= 1'b0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      sh_reg    <= sh_next;
      data_reg  <= data_next;
      en_reg    <= en_next;
    end
  end

  assign tag_data_o = data_reg;
  assign tag_en_o   = en_reg;

  // Out-of-range client ids are still sent (truncated); flag them in simulation.
  node_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (accept && !master_reset_i) |-> (32'(node_id_i) < els_p));

  // Length beyond max_len cannot be encoded; check kept for wider len ports.
  len_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (accept && !master_reset_i) |-> (32'(len_i) <= max_len));

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Self-checking bench for bsg_tag_serial_tx with a behavioural packet model
// and a small bsg_tag_master-style stream decoder.
module tb_bsg_tag_serial_tx;

  localparam int ELS     = 4;
  localparam int LG      = 4;
  localparam int GAP     = 2;
  localparam int RLEN    = 20;
  localparam int NODE_W  = 2;
  localparam int MAX_LEN = 15;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               v = 1'b0;
  logic               master_reset = 1'b0;
  logic [NODE_W-1:0]  node_id = '0;
  logic               dnr = 1'b0;
  logic [LG-1:0]      len = '0;
  logic [MAX_LEN-1:0] payload = '0;
  logic               ready, tag_data, tag_en, busy;

  int vectors = 0;
  int miscompares = 0;

  bit exp_q[$];
  bit got_d[$];
  bit got_e[$];
  bit got_r[$];
  bit stream[$];

  always #5 clk = ~clk;

  bsg_tag_serial_tx #(
    .els_p(ELS), .lg_width_p(LG), .gap_p(GAP), .reset_len_p(RLEN)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready),
    .master_reset_i(master_reset), .node_id_i(node_id),
    .data_not_reset_i(dnr), .len_i(len), .payload_i(payload),
    .tag_data_o(tag_data), .tag_en_o(tag_en), .busy_o(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected on-wire bits for one command, straight from the packet format.
  function automatic void model_packet(input bit mr, input int n, input bit d,
                                       input int l, input int p);
    exp_q.delete();
    if (mr) begin
      for (int i = 0; i < RLEN; i++) exp_q.push_back(1'b1);
    end else begin
      exp_q.push_back(1'b1);
      for (int i = 0; i < NODE_W; i++) exp_q.push_back(bit'((n >> i) & 1));
      exp_q.push_back(d);
      for (int i = 0; i < LG; i++) exp_q.push_back(bit'((l >> i) & 1));
      for (int i = 0; i < l; i++) exp_q.push_back(bit'((p >> i) & 1));
    end
    for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
  endfunction

  // Master-side decoder: reset on a long run of ones, then start-bit framed packets.
  task automatic decode_stream(output bit rst_seen, output int npk, output int dn,
                               output bit dd, output int dl, output int dp);
    int i, run, p;
    rst_seen = 0; npk = 0; dn = 0; dd = 0; dl = 0; dp = 0;
    i = 0;
    while (i < stream.size()) begin
      if (!stream[i]) begin
        i++;
      end else begin
        run = 0;
        while (i + run < stream.size() && stream[i + run]) run++;
        if (run >= RLEN) begin
          rst_seen = 1;
          i += run;
        end else if (!rst_seen) begin
          i++;
        end else begin
          p = i + 1;
          if (p + NODE_W + 1 + LG > stream.size()) break;
          dn = 0;
          for (int k = 0; k < NODE_W; k++) dn |= int'(stream[p + k]) << k;
          p += NODE_W;
          dd = stream[p];
          p++;
          dl = 0;
          for (int k = 0; k < LG; k++) dl |= int'(stream[p + k]) << k;
          p += LG;
          if (p + dl > stream.size()) break;
          dp = 0;
          for (int k = 0; k < dl; k++) dp |= int'(stream[p + k]) << k;
          p += dl;
          npk++;
          i = p;
        end
      end
    end
  endtask

  // Present a command for one accepting edge, then scramble the inputs.
  task automatic drive_cmd(input bit mr, input int n, input bit d, input int l, input int p);
    @(negedge clk);
    master_reset = mr;
    node_id      = NODE_W'(n);
    dnr          = d;
    len          = LG'(l);
    payload      = MAX_LEN'(p);
    v            = 1'b1;
    @(posedge clk);
    #1;
    v            = 1'b0;
    master_reset = 1'($urandom);
    node_id      = NODE_W'($urandom);
    dnr          = 1'($urandom);
    len          = LG'($urandom);
    payload      = MAX_LEN'($urandom);
  endtask

  task automatic capture(input int n);
    got_d.delete(); got_e.delete(); got_r.delete();
    repeat (n) begin
      @(negedge clk);
      got_d.push_back(tag_data);
      got_e.push_back(tag_en);
      got_r.push_back(ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tag_data, tag_en, ready, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_hold: got d/en/rdy/busy=%b want 0010", {tag_data, tag_en, ready, busy});
    end
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({tag_data, tag_en, ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL reset_release cyc %0d: got d/en/rdy=%b want 001", c, {tag_data, tag_en, ready});
      end
    end
    $display("test_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_data_pkt();
    bit seq[13] = '{1,0,1,1,1,1,0,0,1,0,1,0,0};
    drive_cmd(1'b0, 2, 1'b1, 3, 5);
    capture(13);
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if ({got_d[k], got_e[k], got_r[k]} !== {seq[k], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL data_pkt bit %0d: got d/en/rdy=%b%b%b want %b10", k, got_d[k], got_e[k], got_r[k], seq[k]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({tag_data, tag_en, ready, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL data_pkt_idle: got d/en/rdy/busy=%b want 0010", {tag_data, tag_en, ready, busy});
    end
    $display("test_data_pkt done: node=2 dnr=1 len=3 payload=101");
  endtask

  task automatic test_master_reset();
    drive_cmd(1'b1, 0, 1'b0, 0, 0);
    capture(RLEN + GAP);
    for (int k = 0; k < RLEN + GAP; k++) begin
      vectors++;
      if ({got_d[k], got_e[k]} !== {(k < RLEN) ? 1'b1 : 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL master_reset bit %0d: got d/en=%b%b want %b1", k, got_d[k], got_e[k], (k < RLEN));
      end
    end
    @(negedge clk);
    vectors++;
    if ({tag_data, tag_en, ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL master_reset_idle: got d/en/rdy=%b want 001", {tag_data, tag_en, ready});
    end
    $display("test_master_reset done: %0d ones + %0d zeros", RLEN, GAP);
  endtask

  task automatic test_len_zero();
    bit seq[10] = '{1,1,1,0,0,0,0,0,0,0};
    drive_cmd(1'b0, 3, 1'b0, 0, 32'h7fff);
    capture(10);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({got_d[k], got_e[k]} !== {seq[k], 1'b1}) begin
        miscompares++;
        $display("FAIL len_zero bit %0d: got d/en=%b%b want %b1", k, got_d[k], got_e[k], seq[k]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({tag_data, tag_en, ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL len_zero_idle: got d/en/rdy=%b want 001", {tag_data, tag_en, ready});
    end
    $display("test_len_zero done: node=3 dnr=0 len=0");
  endtask

  task automatic test_back_to_back();
    int an, al, ap, bn, bl, bp;
    bit ad, bd, took;
    bit expa[$];
    an = $urandom_range(0, ELS - 1); ad = 1'($urandom); al = $urandom_range(0, MAX_LEN); ap = $urandom;
    bn = $urandom_range(0, ELS - 1); bd = 1'($urandom); bl = $urandom_range(0, MAX_LEN); bp = $urandom;
    model_packet(1'b0, an, ad, al, ap);
    expa = exp_q;
    @(negedge clk);
    master_reset = 1'b0; node_id = NODE_W'(an); dnr = ad; len = LG'(al); payload = MAX_LEN'(ap);
    v = 1'b1;
    @(posedge clk);
    #1;
    master_reset = 1'b0; node_id = NODE_W'(bn); dnr = bd; len = LG'(bl); payload = MAX_LEN'(bp);
    got_d.delete(); got_e.delete(); got_r.delete();
    took = 0;
    for (int c = 0; c < 100 && !took; c++) begin
      @(negedge clk);
      got_d.push_back(tag_data); got_e.push_back(tag_en); got_r.push_back(ready);
      if (ready) begin
        @(posedge clk);
        #1;
        v = 1'b0;
        took = 1;
      end
    end
    v = 1'b0;
    vectors++;
    if (!took || got_d.size() != expa.size() + 1) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles before 2nd accept want %0d", got_d.size(), expa.size() + 1);
    end else begin
      for (int k = 0; k < expa.size(); k++) begin
        vectors++;
        if ({got_d[k], got_e[k], got_r[k]} !== {expa[k], 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL b2b_first bit %0d: got d/en/rdy=%b%b%b want %b10", k, got_d[k], got_e[k], got_r[k], expa[k]);
        end
      end
      vectors++;
      if ({got_d[expa.size()], got_e[expa.size()], got_r[expa.size()]} !== 3'b001) begin
        miscompares++;
        $display("FAIL b2b_between: got d/en/rdy=%b%b%b want 001", got_d[expa.size()], got_e[expa.size()], got_r[expa.size()]);
      end
      model_packet(1'b0, bn, bd, bl, bp);
      capture(exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if ({got_d[k], got_e[k]} !== {exp_q[k], 1'b1}) begin
          miscompares++;
          $display("FAIL b2b_second bit %0d: got d/en=%b%b want %b1", k, got_d[k], got_e[k], exp_q[k]);
        end
      end
      @(negedge clk);
    end
    $display("test_back_to_back done: A len=%0d B len=%0d", al, bl);
  endtask

  task automatic test_reset_midpacket();
    int pn, pl, pp, dn, dl, dp, npk;
    bit pd, dd, rs;
    drive_cmd(1'b0, 2, 1'b1, 3, 5);
    capture(4);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({tag_data, tag_en, ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL midpkt_reset_now: got d/en/rdy=%b want 001", {tag_data, tag_en, ready});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({tag_data, tag_en, ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL midpkt_after_release: got d/en/rdy=%b want 001", {tag_data, tag_en, ready});
    end
    stream.delete();
    drive_cmd(1'b1, 0, 1'b0, 0, 0);
    capture(RLEN + GAP);
    for (int k = 0; k < got_d.size(); k++) if (got_e[k]) stream.push_back(got_d[k]);
    @(negedge clk);
    pn = $urandom_range(0, ELS - 1); pd = 1'($urandom); pl = $urandom_range(1, 8); pp = $urandom_range(0, 32767);
    model_packet(1'b0, pn, pd, pl, pp);
    drive_cmd(1'b0, pn, pd, pl, pp);
    capture(exp_q.size());
    for (int k = 0; k < got_d.size(); k++) if (got_e[k]) stream.push_back(got_d[k]);
    @(negedge clk);
    decode_stream(rs, npk, dn, dd, dl, dp);
    vectors++;
    if (rs !== 1'b1 || npk != 1) begin
      miscompares++;
      $display("FAIL midpkt_decode_frame: got reset=%0d pkts=%0d want reset=1 pkts=1", rs, npk);
    end
    vectors++;
    if (dn != pn || dd !== pd || dl != pl || dp != (pp & ((1 << pl) - 1))) begin
      miscompares++;
      $display("FAIL midpkt_decode_fields: got n=%0d d=%0d l=%0d p=%0h want n=%0d d=%0d l=%0d p=%0h",
               dn, dd, dl, dp, pn, pd, pl, pp & ((1 << pl) - 1));
    end
    $display("test_reset_midpacket done: decoded node=%0d len=%0d", dn, dl);
  endtask

  task automatic test_random();
    int n, l, p;
    bit mr, d;
    for (int t = 0; t < 25; t++) begin
      mr = ($urandom_range(0, 7) == 0);
      n = $urandom_range(0, ELS - 1); d = 1'($urandom); l = $urandom_range(0, MAX_LEN); p = $urandom;
      model_packet(mr, n, d, l, p);
      drive_cmd(mr, n, d, l, p);
      capture(exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if ({got_d[k], got_e[k], got_r[k]} !== {exp_q[k], 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL random t%0d bit %0d: got d/en/rdy=%b%b%b want %b10", t, k, got_d[k], got_e[k], got_r[k], exp_q[k]);
        end
      end
      @(negedge clk);
      vectors++;
      if ({tag_data, tag_en, ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL random_idle t%0d: got d/en/rdy=%b want 001", t, {tag_data, tag_en, ready});
      end
      $display("random cmd %0d: mr=%0d node=%0d dnr=%0d len=%0d bits=%0d", t, mr, n, d, l, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_data_pkt();
    test_master_reset();
    test_len_zero();
    test_back_to_back();
    test_reset_midpacket();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
